// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory front end.
package mem_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 9;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef logic [0:0] state_t;
   localparam state_t IDLE   = 1'b0;
   localparam state_t RMW_WR = 1'b1;

endpackage

// File: rtl/load_extender.sv
// Lane select plus sign/zero extension of a memory word; shared with MEM/WB forwarding.
module load_extender
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_signed,
   input  logic [1:0]  byte_off,
   input  logic [31:0] word,
   output logic [31:0] result
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   always_comb begin
      lane_byte = word[{byte_off, 3'b000} +: 8];
      lane_half = byte_off[1] ? word[31:16] : word[15:0];
      case (size)
         SIZE_BYTE: result = {{24{is_signed & lane_byte[7]}}, lane_byte};
         SIZE_HALF: result = {{16{is_signed & lane_half[15]}}, lane_half};
         default:   result = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Turns byte/half/word loads and stores into word accesses; sub-word stores
// run a read cycle (stalling) followed by a write of the merged word.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_mem_read,
   input  logic                  i_mem_write,
   input  logic [1:0]            i_mem_size,
   input  logic                  i_mem_signed,
   input  logic [31:0]           i_addr,
   input  logic [31:0]           i_store_data,
   input  logic [31:0]           i_dm_read_data,
   output logic [ADDR_WIDTH-1:0] o_dm_address,
   output logic [31:0]           o_dm_write_data,
   output logic                  o_dm_write,
   output logic [31:0]           o_load_data,
   output logic                  o_stall,
   output logic                  o_misaligned,
   output logic [31:0]           o_fault_addr
);

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [31:0]           data_reg;
   logic [31:0]           fault_reg;

   logic                  idle_active, is_half, is_word, bad_align;
   logic                  misaligned, word_store, sub_store, load_ok;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [3:0]            lane_en;
   logic [31:0]           store_src, merged_word, ext_word;

   assign word_addr   = i_addr[ADDR_WIDTH+1:2];
   // The instruction held on the inputs during RMW_WR must not start a new access.
   assign idle_active = (state_reg == IDLE) && !reset;
   assign is_half     = (i_mem_size == SIZE_HALF);
   assign is_word     = (i_mem_size == SIZE_WORD) || (i_mem_size == SIZE_RSVD);
   assign bad_align   = (is_half & i_addr[0]) | (is_word & (i_addr[1:0] != 2'b00));

   assign misaligned  = idle_active & (i_mem_read | i_mem_write) & bad_align;
   assign word_store  = idle_active & i_mem_write & is_word & !bad_align;
   assign sub_store   = idle_active & i_mem_write & !is_word & !bad_align;
   assign load_ok     = idle_active & i_mem_read & !bad_align;

   assign store_src = is_half ? {2{i_store_data[15:0]}} : {4{i_store_data[7:0]}};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_en[gi] = is_half ? (i_addr[1] == (gi >= 2)) : (i_addr[1:0] == 2'(gi));
         assign merged_word[gi*8 +: 8] = lane_en[gi] ? store_src[gi*8 +: 8]
                                                     : i_dm_read_data[gi*8 +: 8];
      end
   endgenerate

   load_extender u_load_extender (
      .size      (i_mem_size),
      .is_signed (i_mem_signed),
      .byte_off  (i_addr[1:0]),
      .word      (i_dm_read_data),
      .result    (ext_word)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (sub_store) state_next = RMW_WR;
         RMW_WR:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         data_reg  <= '0;
         fault_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (sub_store) begin
            addr_reg <= word_addr;
            data_reg <= merged_word;
         end
         if (misaligned) fault_reg <= i_addr;
      end
   end

   assign o_dm_address    = (state_reg == RMW_WR) ? addr_reg : word_addr;
   assign o_dm_write_data = (state_reg == RMW_WR) ? data_reg
                          : (is_word ? i_store_data : merged_word);
   assign o_dm_write      = ((state_reg == RMW_WR) && !reset) || word_store;
   assign o_stall         = sub_store;
   assign o_misaligned    = misaligned;
   assign o_load_data     = load_ok ? ext_word : 32'h0;
   assign o_fault_addr    = fault_reg;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage front end sitting directly upstream of the word-wide data memory (9-bit word address, 32-bit data, async read, sync write).
- Converts byte/halfword/word loads and stores from the EX/MEM register into word accesses:
  - sub-word loads use lane extraction plus sign/zero extension;
  - sub-word stores use a 2-cycle read-modify-write that stalls the pipeline for one cycle.
- Flags misaligned accesses.

Parameters:
- ADDR_WIDTH, 9, word-address width driven to data memory; byte address bits [ADDR_WIDTH+1:2] used, higher bits ignored.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- i_mem_read  input  1  load request this cycle
- i_mem_write  input  1  store request this cycle
- i_mem_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- i_mem_signed  input  1  1 = sign-extend sub-word load, 0 = zero-extend
- i_addr  input  32  byte address
- i_store_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- i_dm_read_data  input  32  word returned by data memory (combinational)
- o_dm_address  output  ADDR_WIDTH  word address to data memory
- o_dm_write_data  output  32  word to data memory
- o_dm_write  output  1  data memory write enable
- o_load_data  output  32  extended load result to MEM/WB
- o_stall  output  1  hold PC/IF/ID/EX/MEM registers this cycle
- o_misaligned  output  1  misaligned access this cycle (combinational)
- o_fault_addr  output  32  byte address of most recent misaligned access (registered, sticky)

Behaviour:
- Little-endian lanes: addr[1:0]=0 → bits[7:0], 1 → [15:8], 2 → [23:16], 3 → [31:24]. Halfword lane: addr[1]=0 → [15:0], 1 → [31:16].
- Misaligned conditions:
  - halfword with addr[0]=1;
  - word/reserved with addr[1:0]≠0.
  - Effect: o_misaligned=1, o_dm_write=0, no RMW, o_stall=0; o_fault_addr <= i_addr at clock edge.
- FSM states: IDLE, RMW_WR.
- IDLE, word store (aligned):
  - o_dm_address = i_addr word index; o_dm_write_data = i_store_data; o_dm_write=1; o_stall=0.
  - Single cycle; stay IDLE.
- IDLE, sub-word store (aligned):
  - o_dm_address driven, o_dm_write=0, o_stall=1.
  - On edge: latch address into addr_q; latch merged word into data_q = i_dm_read_data with target lane replaced by i_store_data low byte/half. Go to RMW_WR.
- RMW_WR:
  - o_dm_address=addr_q, o_dm_write_data=data_q, o_dm_write=1, o_stall=0.
  - All request inputs ignored; the held instruction still on inputs must not retrigger.
  - Next state IDLE.
- Loads (IDLE, aligned):
  - Single cycle, combinational path from i_dm_read_data.
  - Byte/half lane selected, then bit 7/15 replicated when i_mem_signed=1, else zero-filled. Word passes through.
  - o_load_data is a don't-care-free value: 0 when no load or misaligned.
- i_mem_read and i_mem_write both high: store behaviour wins; o_load_data still reflects the load decode of the same address.
- No request: o_dm_write=0, o_stall=0, o_dm_address tracks i_addr.
- Reset (sync) behaviour:
  - State → IDLE; addr_q, data_q, o_fault_addr → 0.
  - During reset cycle outputs are: o_dm_write=0, o_stall=0, o_misaligned=0, o_load_data=0.
  - Reset asserted in RMW_WR suppresses that write.
- Address wrap: bits above ADDR_WIDTH+1 discarded; 0x800 maps to word 0.
- Back-to-back sub-word stores: second begins its read cycle in the cycle after RMW_WR; RMW_WR write and next read never overlap.

Decomposition:
- Shared package mem_pkg:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - FSM state enum (IDLE, RMW_WR);
  - ADDR_WIDTH default.
- One natural sub-module, load_extender: combinational lane select plus sign/zero extension (size, signed, addr[1:0], word → 32-bit result), reused by the MEM/WB forwarding path.

Test Plan:
- Word store/read-back:
  - sw 0xDEADBEEF to 0x010 → o_dm_write=1, o_dm_address=4, o_stall=0 for one cycle.
  - lw 0x010 → o_load_data=0xDEADBEEF.
- Byte store RMW:
  - Memory word 4 holds 0x11223344; sb 0xAA to 0x012.
  - Cycle 1: o_stall=1, o_dm_write=0.
  - Cycle 2: o_dm_write=1, o_dm_write_data=0x11AA3344, o_stall=0.
- Signed/unsigned loads from word 0x80FF7F01:
  - lb@+1 → 0x0000007F; lb@+2 → 0xFFFFFFFF; lbu@+3 → 0x00000080; lh@+2 → 0xFFFF80FF; lhu@+0 → 0x00007F01.
- Misaligned accesses:
  - sh to 0x013 → o_misaligned=1, o_dm_write=0, o_stall=0, next cycle o_fault_addr=0x00000013.
  - lw 0x006 → o_misaligned=1, o_load_data=0.
- Reset mid-RMW: sb issued, reset asserted in RMW_WR cycle → o_dm_write=0 that cycle, memory unchanged, state IDLE.
- Back-to-back sb to 0x020 then sh to 0x022 (word initially 0):
  - Stall pattern 1,0,1,0.
  - Writes 0x000000xx then 0xyyyy00xx.
  - Final word correct.
